// File: rtl/afifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signal bundle of the async FIFO write-port arbiter.
// master drives requests and the full flag; slave is the arbiter.
interface afifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        REQ_VALID;
    logic [N_REQ*DATA_W-1:0] REQ_DATA;
    logic [N_REQ-1:0]        REQ_LAST;
    logic [N_REQ-1:0]        REQ_READY;
    logic                    FIFO_WR_EN;
    logic [DATA_W:0]         FIFO_WR_DATA;
    logic                    FIFO_FULL;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
        input  REQ_READY, FIFO_WR_EN, FIFO_WR_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
        output REQ_READY, FIFO_WR_EN, FIFO_WR_DATA
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, frame-atomic arbiter for the write port of an async FIFO.
// Define AFIFO_WR_ARB_STATS_EN to add FRAME_CNT / TRUNC_CNT statistics outputs.
module afifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                     WR_CLK,
    input  logic                     WR_RST,
    afifo_wr_arbiter_if.slave        bus,
    output logic [$clog2(N_REQ)-1:0] GRANT_ID,
    output logic                     BUSY,
    output logic                     TRUNC_ERR
`ifdef AFIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]              FRAME_CNT,
    output logic [15:0]              TRUNC_CNT
`endif
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;

    logic [DATA_W-1:0] g_data;
    logic              g_valid;
    logic              g_last;
    logic              force_last;
    logic              wr;
    logic              done;
    logic [GW-1:0]     g_next;
    logic [GW-1:0]     pick;
    logic              found;
    logic [N_REQ-1:0]  ready;

    assign g_valid    = bus.REQ_VALID[grant_q];
    assign g_last     = bus.REQ_LAST[grant_q];
    assign g_data     = bus.REQ_DATA[int'(grant_q)*DATA_W +: DATA_W];
    assign force_last = (cnt_q == CNT_W'(MAX_WORDS - 1));
    assign wr         = (state_q == XFER) && g_valid && !bus.FIFO_FULL;
    assign done       = wr && (g_last || force_last);
    assign g_next     = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // First valid requester at or after rr_q, wrapping past N_REQ-1.
    always_comb begin
        int idx;
        logic [GW-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = GW'(idx);
            if (!found && bus.REQ_VALID[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                ready[grant_q] = !bus.FIFO_FULL;
                if (wr) begin
                    cnt_d   = cnt_q + 1'b1;
                    trunc_d = force_last;
                    if (g_last) begin
                        rr_d    = g_next;
                        state_d = IDLE;
                    end else if (force_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Tail of a truncated frame is acked and discarded.
                ready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    rr_d    = g_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge WR_CLK or posedge WR_RST) begin
        if (WR_RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.REQ_READY    = ready;
    assign bus.FIFO_WR_EN   = wr;
    assign bus.FIFO_WR_DATA = (state_q == XFER) ? {g_last | force_last, g_data} : '0;
    assign GRANT_ID         = grant_q;
    assign BUSY             = (state_q != IDLE);
    assign TRUNC_ERR        = trunc_q;

`ifdef AFIFO_WR_ARB_STATS_EN
    logic [31:0] frames_q, frames_d;
    logic [15:0] truncs_q, truncs_d;

    always_comb begin
        frames_d = done ? frames_q + 32'd1 : frames_q;
        truncs_d = truncs_q;
        if (wr && force_last && truncs_q != 16'hFFFF) truncs_d = truncs_q + 16'd1;
    end

    always_ff @(posedge WR_CLK or posedge WR_RST) begin
        if (WR_RST) begin
            frames_q <= '0;
            truncs_q <= '0;
        end else begin
            frames_q <= frames_d;
            truncs_q <= truncs_d;
        end
    end

    assign FRAME_CNT = frames_q;
    assign TRUNC_CNT = truncs_q;
`endif
endmodule
